// File: rtl/trap_sequencer.sv
// trap_sequencer: flushes FD/XB, redirects fetch and drains the pipe after a trap or MRET.
// Define TRAP_SEQ_MRET_EN to sequence MRET; otherwise mret is ignored and mret_done stays 0.
module trap_sequencer #(
  parameter int DRAIN_CYCLES = 2,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 initiate_exception,
  input  logic                 mret,
  input  logic [31:0]          csr_mepc,
  input  logic [31:0]          csr_mtvec,
  output logic                 redirect_valid,
  input  logic                 redirect_ready,
  output logic [31:0]          redirect_pc,
  output logic                 flush_fd,
  output logic                 flush_xb,
  output logic                 hold_pipe,
  output logic                 mret_done,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] trap_count
);
  typedef enum logic [1:0] {IDLE, FLUSH, REQ, DRAIN} state_t;
  state_t state, state_nx;
  logic kind_trap;
  logic [3:0] cnt;
  logic mret_req;
  logic take_trap;
`ifdef TRAP_SEQ_MRET_EN
  assign mret_req = mret;
  assign mret_done = state == FLUSH && !kind_trap;
`else
  assign mret_req = mret & 1'b0;
  assign mret_done = 1'b0;
`endif
  // nested faults are accepted while draining, never while the redirect is in flight
  assign take_trap = initiate_exception && (state == IDLE || state == DRAIN);
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  state_nx = (initiate_exception || mret_req) ? FLUSH : IDLE;
      FLUSH: state_nx = REQ;
      REQ:   state_nx = redirect_ready ? DRAIN : REQ;
      DRAIN: state_nx = initiate_exception ? FLUSH : (cnt == 4'd0 ? IDLE : DRAIN);
      default: state_nx = IDLE;
    endcase
  end
  assign flush_fd = state == FLUSH;
  assign flush_xb = state == FLUSH;
  assign redirect_valid = state == REQ;
  assign hold_pipe = state != IDLE;
  assign busy = state != IDLE;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      kind_trap <= 1'b0;
      redirect_pc <= '0;
      cnt <= '0;
      trap_count <= '0;
    end else begin
      state <= state_nx;
      if (take_trap) begin
        redirect_pc <= {csr_mtvec[31:2], 2'b00};
        kind_trap <= 1'b1;
      end else if (state == IDLE && mret_req) begin
        redirect_pc <= {csr_mepc[31:2], 2'b00};
        kind_trap <= 1'b0;
      end
      if (state == REQ && redirect_ready) cnt <= 4'(DRAIN_CYCLES - 1);
      else if (state == DRAIN) cnt <= cnt - 4'd1;
      if (state == FLUSH && kind_trap) trap_count <= trap_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_trap_sequencer.sv
// tb_trap_sequencer: directed table, hand-written corner sequences and random traffic against a cycle model.
module tb_trap_sequencer;
  localparam int DR = 2;
`ifdef TRAP_SEQ_MRET_EN
  localparam bit MEN = 1'b1;
`else
  localparam bit MEN = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b1, ie = 1'b0, mr = 1'b0, rdy = 1'b0;
  logic [31:0] mepc = '0, mtvec = '0;
  logic valid, flush_fd, flush_xb, hold, mret_done, busy;
  logic [31:0] pc, tcount;
  logic valid_w, flush_fd_w, flush_xb_w, hold_w, mret_done_w, busy_w;
  logic [31:0] pc_w;
  logic [1:0] tcount_w;
  always #5 clk = ~clk;
  trap_sequencer #(.DRAIN_CYCLES(DR), .CNT_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .initiate_exception(ie), .mret(mr), .csr_mepc(mepc), .csr_mtvec(mtvec),
    .redirect_valid(valid), .redirect_ready(rdy), .redirect_pc(pc), .flush_fd(flush_fd), .flush_xb(flush_xb),
    .hold_pipe(hold), .mret_done(mret_done), .busy(busy), .trap_count(tcount));
  trap_sequencer #(.DRAIN_CYCLES(DR), .CNT_WIDTH(2)) u_w (
    .clk(clk), .reset(reset), .initiate_exception(ie), .mret(mr), .csr_mepc(mepc), .csr_mtvec(mtvec),
    .redirect_valid(valid_w), .redirect_ready(rdy), .redirect_pc(pc_w), .flush_fd(flush_fd_w), .flush_xb(flush_xb_w),
    .hold_pipe(hold_w), .mret_done(mret_done_w), .busy(busy_w), .trap_count(tcount_w));
  int tests = 0, fails = 0;
  bit m_fl, m_rq, m_trap;
  int m_dr;
  logic [31:0] m_pc, m_cnt;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask
  task automatic model_step;
    bit idle, at, am;
    if (reset) begin
      m_fl = 0; m_rq = 0; m_dr = 0; m_trap = 0; m_pc = '0; m_cnt = '0;
    end else begin
      idle = !m_fl && !m_rq && m_dr == 0;
      at = ie && (idle || m_dr > 0);
      am = MEN && !ie && mr && idle;
      if (m_fl) begin
        m_cnt += 32'(m_trap); m_fl = 0; m_rq = 1;
      end else if (m_rq) begin
        if (rdy) begin m_rq = 0; m_dr = DR; end
      end else if (m_dr > 0) m_dr--;
      if (at || am) begin
        m_fl = 1; m_rq = 0; m_dr = 0; m_trap = at;
        m_pc = (at ? mtvec : mepc) & 32'hFFFF_FFFC;
      end
    end
  endtask
  task automatic model_check;
    bit b = m_fl || m_rq || m_dr > 0;
    chk("m_valid", valid, m_rq);
    chk("m_flush_fd", flush_fd, m_fl);
    chk("m_flush_xb", flush_xb, m_fl);
    chk("m_hold", hold, b);
    chk("m_busy", busy, b);
    chk("m_mret_done", mret_done, m_fl && !m_trap);
    chk("m_pc", pc, m_pc);
    chk("m_count", tcount, m_cnt);
    chk("m_count_wrap", tcount_w, m_cnt & 32'd3);
  endtask
  task automatic cyc(input bit i, input bit m, input bit r, input bit rs, input logic [31:0] tv, input logic [31:0] ep);
    ie = i; mr = m; rdy = r; reset = rs; mtvec = tv; mepc = ep;
    @(posedge clk);
    model_step;
    @(negedge clk);
    model_check;
  endtask
  typedef struct {
    bit i, m, r, rs;
    logic [31:0] tv, ep;
    bit v, h, f, md;
    logic [31:0] pc, cnt;
  } vec_t;
  vec_t tbl[$];
  function automatic vec_t mk(bit i, bit m, bit r, bit rs, logic [31:0] tv, logic [31:0] ep,
                              bit v, bit h, bit f, bit md, logic [31:0] p, logic [31:0] c);
    vec_t x;
    x.i = i; x.m = m; x.r = r; x.rs = rs; x.tv = tv; x.ep = ep;
    x.v = v; x.h = h; x.f = f; x.md = md; x.pc = p; x.cnt = c;
    return x;
  endfunction
  initial begin
    logic [31:0] mp;
    mp = MEN ? 32'h2000 : 32'h104;
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 1, 0, 32'h104, 0, 0, 1, 1, 0, 32'h104, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 1, 1, 0, 0, 32'h104, 1));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 32'h104, 1));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 32'h104, 1));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 32'h104, 1));
    tbl.push_back(mk(0, 1, 1, 0, 0, 32'h2003, 0, MEN, MEN, MEN, mp, 1));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, MEN, MEN, 0, 0, mp, 1));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, MEN, 0, 0, mp, 1));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, MEN, 0, 0, mp, 1));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, mp, 1));
    tbl.push_back(mk(1, 1, 1, 0, 32'h100, 32'h200, 0, 1, 1, 0, 32'h100, 1));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 1, 1, 0, 0, 32'h100, 2));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 32'h100, 2));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 32'h100, 2));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 32'h100, 2));
    foreach (tbl[k]) begin
      cyc(tbl[k].i, tbl[k].m, tbl[k].r, tbl[k].rs, tbl[k].tv, tbl[k].ep);
      chk($sformatf("t%0d_valid", k), valid, tbl[k].v);
      chk($sformatf("t%0d_hold", k), hold, tbl[k].h);
      chk($sformatf("t%0d_busy", k), busy, tbl[k].h);
      chk($sformatf("t%0d_flush", k), flush_fd & flush_xb, tbl[k].f);
      chk($sformatf("t%0d_mret_done", k), mret_done, tbl[k].md);
      chk($sformatf("t%0d_pc", k), pc, tbl[k].pc);
      chk($sformatf("t%0d_count", k), tcount, tbl[k].cnt);
    end
    // backpressure: exceptions and CSR changes while REQ waits must not disturb the offer
    cyc(0, 0, 0, 1, 0, 0);
    cyc(1, 0, 0, 0, 32'h300, 0);
    cyc(0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      cyc(1, 1, 0, 0, $urandom, $urandom);
      chk("bp_valid", valid, 1);
      chk("bp_pc", pc, 32'h300);
    end
    cyc(0, 0, 1, 0, 0, 0);
    chk("bp_count", tcount, 1);
    chk("bp_drain_hold", hold, 1);
    // nested fault during drain
    cyc(1, 0, 1, 0, 32'h400, 0);
    cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    cyc(1, 0, 1, 0, 32'h501, 0);
    chk("nest_flush", flush_fd, 1);
    chk("nest_pc", pc, 32'h500);
    cyc(0, 0, 1, 0, 0, 0);
    chk("nest_count", tcount, 3);
    // reset while the redirect is pending
    cyc(1, 0, 0, 0, 32'h600, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("rst_pre_valid", valid, 1);
    cyc(0, 0, 0, 1, 0, 0);
    chk("rst_valid", valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_count", tcount, 0);
    cyc(0, 0, 1, 0, 0, 0);
    chk("rst_stays_idle", hold, 0);
    for (int k = 0; k < 2000; k++)
      cyc($urandom_range(0, 5) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 2) != 0,
          $urandom_range(0, 150) == 0, $urandom, $urandom);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
